// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial W-bit subtractor: one full-subtractor cell stepped LSB-first.
// Ports: clk, rst_n, start, a, b, bin -> busy, done, diff (a-b-bin), bout.

module full_subtractor_gate (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   assign D    = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

module serial_subtractor_ctrl #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         bout
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  r_sh;
   logic [W-1:0]  r_next;
   logic [W-1:0]  diff_q;
   logic          bout_q;
   logic          brw;
   logic [CW-1:0] cnt;

   logic cell_d;
   logic cell_bout;
   logic load;
   logic last;

   full_subtractor_gate u_cell (
      .A    (a_sh[0]),
      .B    (b_sh[0]),
      .Bin  (brw),
      .D    (cell_d),
      .Bout (cell_bout)
   );

   // Result fills from the MSB side so the LSB lands at bit 0 after W steps.
   generate
      if (W == 1) begin : g_r1
         assign r_next = cell_d;
      end else begin : g_rn
         assign r_next = {cell_d, r_sh[W-1:1]};
      end
   endgenerate

   // Accept in IDLE and in DONE (back-to-back); never while running.
   assign load = start && (state_q != RUN);
   assign last = (state_q == RUN) && (cnt == CW'(W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = start ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (load) begin
         a_sh <= a;
         b_sh <= b;
         brw  <= bin;
         cnt  <= '0;
      end else if (state_q == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         r_sh <= r_next;
         brw  <= cell_bout;
         cnt  <= cnt + CW'(1);
         if (last) begin
            diff_q <= r_next;
            bout_q <= cell_bout;
         end
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: W=8 directed/random ops, W=1 truth table.
// Reference results come from plain integer subtraction.

module tb_serial_subtractor_ctrl;

   logic       clk;
   logic       rst_n;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       bin8;
   logic       busy8;
   logic       done8;
   logic [7:0] diff8;
   logic       bout8;

   logic       start1;
   logic       a1;
   logic       b1;
   logic       bin1;
   logic       busy1;
   logic       done1;
   logic       diff1;
   logic       bout1;

   int checks;
   int failures;

   logic [7:0] exp_diff;
   logic       exp_bout;

   serial_subtractor_ctrl #(.W(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .bin   (bin8),
      .busy  (busy8),
      .done  (done8),
      .diff  (diff8),
      .bout  (bout8)
   );

   serial_subtractor_ctrl #(.W(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .bin   (bin1),
      .busy  (busy1),
      .done  (done1),
      .diff  (diff1),
      .bout  (bout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer subtraction, wrapped to 8 bits, borrow on negative.
   task automatic model8(input logic [7:0] a, input logic [7:0] b,
                         input logic bi);
      int r;
      r = int'(a) - int'(b) - int'(bi);
      exp_diff = r[7:0];
      exp_bout = (r < 0);
   endtask

   // Called at the negedge just after the accepting edge (k = k0).
   // Returns k at which done was seen (99 if never within budget).
   task automatic wait_done(input int k0, output int k);
      k = k0;
      while (!done8 && k < 30) begin
         @(negedge clk);
         k++;
      end
      if (!done8) k = 99;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic bi);
      int nb;
      bit seen;
      logic [7:0] old_d;
      logic       old_b;
      old_d = exp_diff;
      old_b = exp_bout;
      start8 = 1'b1;
      a8 = a;
      b8 = b;
      bin8 = bi;
      @(negedge clk);
      start8 = 1'b0;
      nb = 0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (done8) begin
            seen = 1'b1;
         end else begin
            if (busy8) nb++;
            check("hold_diff", diff8, old_d);
            check("hold_bout", 8'(bout8), 8'(old_b));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            bin8 = 1'($urandom);
            @(negedge clk);
         end
      end
      model8(a, b, bi);
      check("done_seen", 8'(seen), 8'd1);
      check("busy_cycles", 8'(nb), 8'd8);
      check("diff", diff8, exp_diff);
      check("bout", 8'(bout8), 8'(exp_bout));
      @(negedge clk);
      check("done_pulse", 8'(done8), 8'd0);
   endtask

   initial begin
      int k;
      int nd;
      int r;
      checks = 0;
      failures = 0;
      exp_diff = '0;
      exp_bout = 1'b0;
      rst_n = 1'b0;
      start8 = 1'b0;
      a8 = '0;
      b8 = '0;
      bin8 = 1'b0;
      start1 = 1'b0;
      a1 = 1'b0;
      b1 = 1'b0;
      bin1 = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_busy", 8'(busy8), 8'd0);
      check("rst_done", 8'(done8), 8'd0);
      check("rst_diff", diff8, 8'h00);
      check("rst_bout", 8'(bout8), 8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic and borrow cases
      run_op(8'h5A, 8'h3C, 1'b0);
      check("basic_diff", diff8, 8'h1E);
      run_op(8'h00, 8'h01, 1'b0);
      check("b1_diff", diff8, 8'hFF);
      check("b1_bout", 8'(bout8), 8'd1);
      run_op(8'hFF, 8'hFF, 1'b1);
      check("b2_diff", diff8, 8'hFF);
      check("b2_bout", 8'(bout8), 8'd1);
      run_op(8'h80, 8'h7F, 1'b1);
      check("b3_diff", diff8, 8'h00);
      check("b3_bout", 8'(bout8), 8'd0);

      // Start re-pulsed mid-run is ignored
      start8 = 1'b1;
      a8 = 8'h5A;
      b8 = 8'h3C;
      bin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      start8 = 1'b1;
      a8 = 8'h11;
      b8 = 8'h22;
      @(negedge clk);
      start8 = 1'b0;
      wait_done(4, k);
      check("repulse_lat", 8'(k), 8'd8);
      check("repulse_diff", diff8, 8'h1E);
      check("repulse_bout", 8'(bout8), 8'd0);
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) nd++;
      end
      check("repulse_no_2nd", 8'(nd), 8'd0);

      // Back-to-back: start held through DONE
      start8 = 1'b1;
      a8 = 8'h5A;
      b8 = 8'h3C;
      bin8 = 1'b0;
      @(negedge clk);
      a8 = 8'h10;
      b8 = 8'h01;
      wait_done(0, k);
      check("b2b_lat1", 8'(k), 8'd8);
      check("b2b_diff1", diff8, 8'h1E);
      @(negedge clk);
      check("b2b_busy", 8'(busy8), 8'd1);
      check("b2b_nodone", 8'(done8), 8'd0);
      check("b2b_hold", diff8, 8'h1E);
      start8 = 1'b0;
      wait_done(0, k);
      check("b2b_lat2", 8'(k), 8'd8);
      check("b2b_diff2", diff8, 8'h0F);
      check("b2b_bout2", 8'(bout8), 8'd0);
      @(negedge clk);
      check("b2b_end", 8'(done8), 8'd0);

      // Asynchronous reset in the middle of a run
      start8 = 1'b1;
      a8 = 8'h33;
      b8 = 8'h44;
      bin8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", 8'(busy8), 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 8'(busy8), 8'd0);
      check("arst_done", 8'(done8), 8'd0);
      check("arst_diff", diff8, 8'h00);
      check("arst_bout", 8'(bout8), 8'd0);
      exp_diff = '0;
      exp_bout = 1'b0;
      nd = 0;
      repeat (3) begin
         @(negedge clk);
         if (done8) nd++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (done8) nd++;
      end
      check("arst_no_done", 8'(nd), 8'd0);
      run_op(8'hC3, 8'h5D, 1'b1);

      // Random operations
      for (int i = 0; i < 12; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom));
      end

      // W=1 exhaustive truth table
      for (int i = 0; i < 8; i++) begin
         a1 = i[2];
         b1 = i[1];
         bin1 = i[0];
         r = int'(a1) - int'(b1) - int'(bin1);
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         check("w1_busy", 8'(busy1), 8'd1);
         check("w1_early", 8'(done1), 8'd0);
         @(negedge clk);
         check("w1_done", 8'(done1), 8'd1);
         check("w1_diff", 8'(diff1), 8'(r[0]));
         check("w1_bout", 8'(bout1), 8'(r < 0));
         @(negedge clk);
         check("w1_pulse", 8'(done1), 8'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
